// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: configurable data width, parity and stop bits, valid/ready holding register.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote over the three ticks ending at each sample point.
module uart_rx_os #(
  parameter int CLK_FREQ   = 1000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int BI_W    = $clog2(DATA_BITS + 1);

  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] BI_LAST = BI_W'(DATA_BITS - 1);
  localparam logic            ST_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 sync1_reg;
  logic                 rxs_reg;
  logic [DIV_W-1:0]     div_cnt_reg;
  logic                 tick;
  logic                 bit_val;

  logic [2:0]           state_reg, state_next;
  logic [SC_W-1:0]      sc_reg, sc_next;
  logic [BI_W-1:0]      bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 stop_cnt_reg, stop_cnt_next;
  logic                 fe_acc_reg, fe_acc_next;
  logic                 pe_acc_reg, pe_acc_next;
  logic                 done_reg, done_next;
  logic                 par_xor;

  logic                 rx_valid_reg;
  logic [DATA_BITS-1:0] rx_data_reg;
  logic                 frame_err_reg;
  logic                 parity_err_reg;
  logic                 overrun_reg;

  // Two-flop synchroniser; resets to the idle line level so no false start follows reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b1;
      rxs_reg   <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rxs_reg   <= sync1_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  assign tick = (div_cnt_reg == DIV_W'(DIV - 1));

`ifdef UART_RX_MAJORITY_EN
  // hist_reg[0] holds the sample one tick back, hist_reg[1] two ticks back.
  logic [1:0] hist_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= 2'b11;
    end else if (tick) begin
      hist_reg <= {hist_reg[0], rxs_reg};
    end
  end

  assign bit_val = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rxs_reg) | (hist_reg[0] & rxs_reg);
`else
  assign bit_val = rxs_reg;
`endif

  assign par_xor = (^shift_reg) ^ bit_val;

  always_comb begin
    state_next    = state_reg;
    sc_next       = sc_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    stop_cnt_next = stop_cnt_reg;
    fe_acc_next   = fe_acc_reg;
    pe_acc_next   = pe_acc_reg;
    done_next     = 1'b0;
    if (tick) begin
      case (state_reg)
        S_IDLE: begin
          if (!rxs_reg) begin
            state_next = S_START;
            sc_next    = '0;
          end
        end
        S_START: begin
          if (sc_reg == SC_HALF) begin
            if (!bit_val) begin
              state_next    = S_DATA;
              sc_next       = '0;
              bit_idx_next  = '0;
              stop_cnt_next = 1'b0;
              fe_acc_next   = 1'b0;
              pe_acc_next   = 1'b0;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            sc_next = sc_reg + SC_W'(1);
          end
        end
        S_DATA: begin
          if (sc_reg == SC_LAST) begin
            sc_next      = '0;
            // Right shift: after DATA_BITS bits the first bit received sits in the LSB.
            shift_next   = {bit_val, shift_reg[DATA_BITS-1:1]};
            bit_idx_next = bit_idx_reg + BI_W'(1);
            if (bit_idx_reg == BI_LAST) begin
              state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            end
          end else begin
            sc_next = sc_reg + SC_W'(1);
          end
        end
        S_PARITY: begin
          if (sc_reg == SC_LAST) begin
            sc_next     = '0;
            pe_acc_next = (PARITY == 1) ? ~par_xor : par_xor;
            state_next  = S_STOP;
          end else begin
            sc_next = sc_reg + SC_W'(1);
          end
        end
        S_STOP: begin
          if (sc_reg == SC_LAST) begin
            sc_next = '0;
            if (!bit_val) begin
              fe_acc_next = 1'b1;
            end
            if (stop_cnt_reg == ST_LAST) begin
              state_next = S_IDLE;
              done_next  = 1'b1;
            end else begin
              stop_cnt_next = stop_cnt_reg + 1'b1;
            end
          end else begin
            sc_next = sc_reg + SC_W'(1);
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      sc_reg       <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      stop_cnt_reg <= 1'b0;
      fe_acc_reg   <= 1'b0;
      pe_acc_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sc_reg       <= sc_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      stop_cnt_reg <= stop_cnt_next;
      fe_acc_reg   <= fe_acc_next;
      pe_acc_reg   <= pe_acc_next;
      done_reg     <= done_next;
    end
  end

  // Holding register: a completed frame is dropped (with an overrun pulse) only when
  // the previous word is still unread and not being accepted in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_valid_reg   <= 1'b0;
      rx_data_reg    <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      overrun_reg <= 1'b0;
      if (done_reg) begin
        if (!rx_valid_reg || rx_ready) begin
          rx_valid_reg   <= 1'b1;
          rx_data_reg    <= shift_reg;
          frame_err_reg  <= fe_acc_reg;
          parity_err_reg <= pe_acc_reg;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (rx_valid_reg && rx_ready) begin
        rx_valid_reg <= 1'b0;
      end
    end
  end

  assign rx_valid    = rx_valid_reg;
  assign rx_data     = rx_data_reg;
  assign frame_err   = frame_err_reg;
  assign parity_err  = parity_err_reg;
  assign overrun_err = overrun_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and a 7E2 instance driven with directed frames,
// checked against a queue of expected words built from the frame contents.
module tb_uart_rx_os;

  localparam int CF      = 1600000;
  localparam int BR      = 10000;
  localparam int OS      = 16;
  localparam int TB_DIV  = CF / (BR * OS);
  localparam int BIT_CLK = TB_DIV * OS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_a = 1'b1, rdy_a = 1'b0;
  logic       rx_b = 1'b1, rdy_b = 1'b0;
  logic       vld_a, fe_a, pe_a, ovr_a, busy_a;
  logic [7:0] data_a;
  logic       vld_b, fe_b, pe_b, ovr_b, busy_b;
  logic [6:0] data_b;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .rst(rst), .rx(rx_a), .rx_ready(rdy_a),
    .rx_valid(vld_a), .rx_data(data_a), .frame_err(fe_a),
    .parity_err(pe_a), .overrun_err(ovr_a), .busy(busy_a)
  );

  uart_rx_os #(
    .CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS),
    .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .rst(rst), .rx(rx_b), .rx_ready(rdy_b),
    .rx_valid(vld_b), .rx_data(data_b), .frame_err(fe_b),
    .parity_err(pe_b), .overrun_err(ovr_b), .busy(busy_b)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ph = 0;

  // Expected words: {frame_err, parity_err, data[8:0]}
  logic [10:0] exp_a[$];
  logic [10:0] exp_b[$];

  int rises_a = 0, rises_b = 0, ovr_cnt_a = 0, ovr_cnt_b = 0;
  int rise_cyc_a = 0, last_data_a = 0, last_fe_a = 0, last_pe_a = 0;
  int last_data_b = 0, last_fe_b = 0, last_pe_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit-rate tick phase: free-running divider from reset release, tick when ph == TB_DIV-1.
  always @(posedge clk or negedge rst) begin
    if (!rst) ph <= 0;
    else      ph <= (ph == TB_DIV - 1) ? 0 : ph + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk(input int d, input logic fe, input logic pe);
    return {fe, pe, 9'(d)};
  endfunction

  function automatic logic [15:0] frame_a(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_b(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    return {5'b0, s2, s1, p, d, 1'b0};
  endfunction

  // Even parity: error when data XOR parity bit is 1; any low stop bit is a frame error.
  function automatic logic [10:0] exp_b_word(input logic [6:0] d, input logic p, input logic s1, input logic s2);
    return mk(int'(d), !(s1 && s2), (^d) ^ p);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input int which, input logic v);
    @(posedge clk);
    #2;
    if (which == 0) rdy_a = v;
    else            rdy_b = v;
  endtask

  task automatic drive_rx(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  // Starts the frame so that the receiver's first tick sees the start edge immediately;
  // line value for cycle r is bit r/BIT_CLK, forced high inside [g_lo, g_hi]; stops early at r == cut.
  task automatic send_line(input int which, input logic [15:0] bits, input int nb,
                           input int g_lo, input int g_hi, input int cut, output int t0);
    logic v;
    @(negedge clk);
    while (ph != TB_DIV - 3) @(negedge clk);
    t0 = cyc + 1;
    for (int r = 0; r < nb * BIT_CLK; r++) begin
      if (r == cut) break;
      v = bits[r / BIT_CLK];
      if (r >= g_lo && r <= g_hi) v = 1'b1;
      drive_rx(which, v);
      @(negedge clk);
    end
    if (cut < 0) drive_rx(which, 1'b1);
  endtask

  task automatic wait_rise(input int which, input int old, input string name);
    int n = 0;
    while (((which == 0) ? rises_a : rises_b) <= old && n < 4 * BIT_CLK) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(((which == 0) ? rises_a : rises_b) > old), 1);
  endtask

  // Compare process: every cycle a word is held it must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      prev_a = 1'b0;
      prev_b = 1'b0;
    end else begin
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
      if (vld_a && !prev_a) begin
        rises_a++;
        rise_cyc_a  = cyc;
        last_data_a = int'(data_a);
        last_fe_a   = int'(fe_a);
        last_pe_a   = int'(pe_a);
      end
      if (vld_b && !prev_b) begin
        rises_b++;
        last_data_b = int'(data_b);
        last_fe_b   = int'(fe_b);
        last_pe_b   = int'(pe_b);
      end
      if (vld_a) begin
        check("a_word_expected", int'(exp_a.size() > 0), 1);
        if (exp_a.size() > 0) begin
          check("a_rx_data", int'(data_a), int'(exp_a[0][8:0]));
          check("a_frame_err", int'(fe_a), int'(exp_a[0][10]));
          check("a_parity_err", int'(pe_a), int'(exp_a[0][9]));
          if (rdy_a) void'(exp_a.pop_front());
        end
      end
      if (vld_b) begin
        check("b_word_expected", int'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) begin
          check("b_rx_data", int'(data_b), int'(exp_b[0][8:0]));
          check("b_frame_err", int'(fe_b), int'(exp_b[0][10]));
          check("b_parity_err", int'(pe_b), int'(exp_b[0][9]));
          if (rdy_b) void'(exp_b.pop_front());
        end
      end
      prev_a = vld_a;
      prev_b = vld_b;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, r0, o0, lat;
    logic [7:0] g_exp;

    idle(4);
    check("rst_valid_a", int'(vld_a), 0);
    check("rst_data_a", int'(data_a), 0);
    check("rst_flags_a", int'({fe_a, pe_a, ovr_a}), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_valid_b", int'(vld_b), 0);
    check("rst_busy_b", int'(busy_b), 0);
    rst = 1'b1;
    idle(50);

    // 8N1 0xA5, consumer always ready
    set_ready(0, 1'b1);
    exp_a.push_back(mk('hA5, 1'b0, 1'b0));
    r0 = rises_a;
    send_line(0, frame_a(8'hA5), 10, -1, -1, -1, t0);
    wait_rise(0, r0, "t1_rise");
    check("t1_data", last_data_a, 'hA5);
    check("t1_fe", last_fe_a, 0);
    check("t1_pe", last_pe_a, 0);
    lat = rise_cyc_a - t0;
    check("t1_latency_window", int'(lat > 9 * BIT_CLK + BIT_CLK / 2 && lat <= 9 * BIT_CLK + BIT_CLK / 2 + TB_DIV + 3), 1);
    idle(100);
    check("t1_drained", exp_a.size(), 0);
    check("t1_valid_low", int'(vld_a), 0);

    // 7E2: wrong then correct parity bit, then a low second stop bit
    set_ready(1, 1'b1);
    exp_b.push_back(exp_b_word(7'h55, 1'b1, 1'b1, 1'b1));
    r0 = rises_b;
    send_line(1, frame_b(7'h55, 1'b1, 1'b1, 1'b1), 11, -1, -1, -1, t0);
    wait_rise(1, r0, "t2a_rise");
    check("t2a_data", last_data_b, 'h55);
    check("t2a_pe", last_pe_b, 1);
    idle(200);
    exp_b.push_back(exp_b_word(7'h55, 1'b0, 1'b1, 1'b1));
    r0 = rises_b;
    send_line(1, frame_b(7'h55, 1'b0, 1'b1, 1'b1), 11, -1, -1, -1, t0);
    wait_rise(1, r0, "t2b_rise");
    check("t2b_data", last_data_b, 'h55);
    check("t2b_pe", last_pe_b, 0);
    idle(200);
    exp_b.push_back(exp_b_word(7'h3C, 1'b0, 1'b1, 1'b0));
    r0 = rises_b;
    send_line(1, frame_b(7'h3C, 1'b0, 1'b1, 1'b0), 11, -1, -1, -1, t0);
    wait_rise(1, r0, "t3_rise");
    check("t3_data", last_data_b, 'h3C);
    check("t3_fe", last_fe_b, 1);
    check("t3_pe", last_pe_b, 0);
    idle(300);
    check("t3_drained", exp_b.size(), 0);

    // Overrun: second frame dropped while the first is unread
    set_ready(0, 1'b0);
    exp_a.push_back(mk('h11, 1'b0, 1'b0));
    o0 = ovr_cnt_a;
    r0 = rises_a;
    send_line(0, frame_a(8'h11), 10, -1, -1, -1, t0);
    idle(20);
    send_line(0, frame_a(8'h22), 10, -1, -1, -1, t0);
    idle(100);
    check("t4_rises", rises_a - r0, 1);
    check("t4_overrun_pulses", ovr_cnt_a - o0, 1);
    check("t4_data_held", int'(data_a), 'h11);
    check("t4_valid_held", int'(vld_a), 1);
    @(posedge clk);
    #2 rdy_a = 1'b1;
    check("t4_valid_before_accept", int'(vld_a), 1);
    @(posedge clk);
    #2 rdy_a = 1'b0;
    check("t4_valid_dropped", int'(vld_a), 0);
    check("t4_drained", exp_a.size(), 0);
    set_ready(0, 1'b1);
    idle(20);

    // False start: 40 clk low pulse
    r0 = rises_a;
    @(negedge clk);
    rx_a = 1'b0;
    idle(30);
    check("t5_busy_in_start", int'(busy_a), 1);
    idle(10);
    rx_a = 1'b1;
    idle(200);
    check("t5_false_start_idle", int'(busy_a), 0);
    check("t5_false_start_no_valid", int'(vld_a), 0);
    check("t5_false_start_no_rise", rises_a - r0, 0);

    // Reset in the middle of the data bits
    send_line(0, frame_a(8'h5A), 10, -1, -1, 500, t0);
    check("t5_busy_mid_frame", int'(busy_a), 1);
    rst = 1'b0;
    #1;
    check("t5_rst_valid", int'(vld_a), 0);
    check("t5_rst_data", int'(data_a), 0);
    check("t5_rst_flags", int'({fe_a, pe_a, ovr_a}), 0);
    check("t5_rst_busy", int'(busy_a), 0);
    rx_a = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(50);
    exp_a.push_back(mk('h81, 1'b0, 1'b0));
    r0 = rises_a;
    send_line(0, frame_a(8'h81), 10, -1, -1, -1, t0);
    wait_rise(0, r0, "t5_after_rst_rise");
    check("t5_after_rst_data", last_data_a, 'h81);
    idle(100);

    // One-tick glitch high ending at the nominal sample of data bit 3
`ifdef UART_RX_MAJORITY_EN
    g_exp = 8'h00;
`else
    g_exp = 8'h08;
`endif
    exp_a.push_back(mk(int'(g_exp), 1'b0, 1'b0));
    r0 = rises_a;
    send_line(0, frame_a(8'h00), 10, 4 * BIT_CLK + BIT_CLK / 2 - TB_DIV + 1, 4 * BIT_CLK + BIT_CLK / 2, -1, t0);
    wait_rise(0, r0, "t6_rise");
    check("t6_data", last_data_a, int'(g_exp));
    check("t6_fe", last_fe_a, 0);
    idle(100);

    check("end_drained_a", exp_a.size(), 0);
    check("end_drained_b", exp_b.size(), 0);
    check("end_no_overrun_b", ovr_cnt_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
